// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode, aluop and mux-select encodings for the multicycle MIPS control
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        REXEC, RWB, BEQ, IEXEC, IWB, JUMP, HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Shared with the ALU control decoder; keep in sync with it.
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;

    localparam logic [1:0] ALUSRCB_RT     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic [2:0] iexec_aluop(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALUOP_AND;
            OP_ORI:  return ALUOP_OR;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_timer.sv
// rtl/mips_multicycle_ctrl_timer.sv - memory stall counter with timeout compare
module ctrl_mem_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (active && !mem_ready) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= '0;
        end
    end

    // A completing handshake in the limit cycle wins over the timeout.
    assign timeout = active && !mem_ready && (cnt == LIMIT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS32 main control FSM with retire counter and memory timeout trap
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic [1:0]       pcsrc,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       aluop,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state, next;
    logic [5:0] op_q;
    logic       mem_active;
    logic       timeout;
    logic       retire;

    assign mem_active = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

    ctrl_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (mem_active),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RESET;
            op_q        <= '0;
            bus_error   <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next;
            if (state == DECODE) op_q <= opcode;
            if (next == HALT) bus_error <= 1'b1;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        next       = state;
        retire     = 1'b0;
        pc_en      = 1'b0;
        pcsrc      = PCSRC_ALU;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ALUSRCB_RT;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state)
            RESET: next = FETCH;
            FETCH: begin
                memread = 1'b1;
                alusrcb = ALUSRCB_FOUR;
                irwrite = mem_ready;
                pc_en   = mem_ready;
                if (mem_ready)    next = DECODE;
                else if (timeout) next = HALT;
            end
            DECODE: begin
                alusrcb = ALUSRCB_IMMSL2;
                case (opcode)
                    OP_RTYPE:                 next = REXEC;
                    OP_LW, OP_SW:             next = MEMADR;
                    OP_BEQ:                   next = BEQ;
                    OP_ADDI, OP_ANDI, OP_ORI: next = IEXEC;
                    OP_J:                     next = JUMP;
                    default: begin
                        next       = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
                next    = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready)    next = MEMWB;
                else if (timeout) next = HALT;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
                next     = FETCH;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    next   = FETCH;
                end else if (timeout) begin
                    next = HALT;
                end
            end
            REXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_RTYPE;
                next    = RWB;
            end
            RWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
                next     = FETCH;
            end
            BEQ: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                pc_en   = zero;
                retire  = 1'b1;
                next    = FETCH;
            end
            IEXEC: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
                aluop   = iexec_aluop(op_q);
                next    = IWB;
            end
            IWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                next     = FETCH;
            end
            JUMP: begin
                pcsrc  = PCSRC_JUMP;
                pc_en  = 1'b1;
                retire = 1'b1;
                next   = FETCH;
            end
            HALT: next = HALT;
            default: next = RESET;
        endcase
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS32 core. It sequences the shared ALU, register file, PC and unified memory port across fetch, decode, execute, memory and writeback steps. It drives aluop[2:0] into the existing ALU control decoder and stalls on a memory ready handshake. It also counts retired instructions and traps memory timeouts.

Parameters:
MEM_TIMEOUT, 15, max consecutive stall cycles in any memory state before a bus error is raised (range 1..255).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH.
zero  in  1  ALU zero flag (combinational, same cycle).
mem_ready  in  1  memory handshake; the access completes in a cycle where it is 1.
pc_en  out  1  PC write enable.
pcsrc  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
iord  out  1  memory address select: 0 PC, 1 ALUOut.
memread  out  1  memory read request.
memwrite  out  1  memory write request.
irwrite  out  1  IR load enable.
regdst  out  1  register destination: 0 rt, 1 rd.
memtoreg  out  1  register write data: 0 ALUOut, 1 MDR.
regwrite  out  1  register file write enable.
alusrca  out  1  ALU A input: 0 PC, 1 rs.
alusrcb  out  2  ALU B input: 00 rt, 01 const 4, 10 sign-extended immediate, 11 immediate shifted left 2.
aluop  out  3  000 add, 001 sub, 010 R-type (decode func), 011 and, 100 or.
illegal_op  out  1  one-cycle pulse on an unknown opcode.
bus_error  out  1  sticky; set on memory timeout.
instr_count  out  CNT_W  count of retired instructions.

Behaviour:
- Moore outputs, decoded from the state register; the only Mealy terms are the mem_ready gating and the zero gating noted below. Every output is 0 unless listed for the current state.
- Async reset: state RESET, all outputs 0, instr_count 0, bus_error 0, stall counter 0. RESET goes to FETCH on the next edge.
- FETCH: memread=1, alusrcb=01, aluop=000.
  - irwrite = pc_en = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when it is 1.
- DECODE: alusrcb=11, aluop=000. Latches opcode into op_q. Next state by opcode:
  - 000000 goes to REXEC.
  - 100011 (lw) and 101011 (sw) go to MEMADR.
  - 000100 (beq) goes to BEQ.
  - 001000 (addi), 001100 (andi) and 001101 (ori) go to IEXEC.
  - 000010 (j) goes to JUMP.
  - Any other opcode goes to FETCH with illegal_op=1 for that cycle; instr_count is not incremented.
- MEMADR: alusrca=1, alusrcb=10, aluop=000. Goes to MEMRD if op_q is lw, else MEMWR.
- MEMRD: memread=1, iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: regwrite=1, memtoreg=1. Goes to FETCH.
- MEMWR: memwrite=1, iord=1. Waits for mem_ready, then goes to FETCH.
- REXEC: alusrca=1, alusrcb=00, aluop=010. Goes to RWB.
- RWB: regdst=1, regwrite=1. Goes to FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, pc_en=zero. Goes to FETCH.
- IEXEC: alusrca=1, alusrcb=10. aluop is 000 for addi, 011 for andi, 100 for ori, taken from op_q. Goes to IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. Goes to FETCH.
- JUMP: pcsrc=10, pc_en=1. Goes to FETCH.
- Retirement: instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, BEQ, IWB or JUMP. It wraps modulo 2^CNT_W.
- Stall counter:
  - Increments in each FETCH, MEMRD or MEMWR cycle with mem_ready=0.
  - Clears on mem_ready=1 and on any other state.
  - When the counter equals MEM_TIMEOUT and mem_ready is still 0: go to HALT and set bus_error.
  - If mem_ready=1 arrives in that same cycle, the completion wins and no error is raised.
- HALT: all outputs 0 except bus_error=1. Only reset leaves HALT.
- Reset mid-instruction: immediate return to RESET. No partial regwrite, memwrite or pc_en may be asserted after rst_n falls.
- Single-cycle strobes: regwrite, memwrite and pc_en must never be active for more than one cycle per instruction.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state enum: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BEQ, IEXEC, IWB, JUMP, HALT;
  - opcode constants;
  - aluop constants 000..100, shared with the ALU control decoder;
  - alusrcb and pcsrc encodings.
- One natural sub-module: ctrl_mem_timer, the stall counter plus timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- add (R-type), mem_ready tied to 1 → states FETCH, DECODE, REXEC, RWB; aluop=010 in REXEC; regwrite=1 and regdst=1 for exactly one cycle; instr_count increments from 0 to 1.
- lw with mem_ready low for 3 cycles in MEMRD → iord=1 held for 4 cycles; MEMWB then asserts regwrite=1 and memtoreg=1; total 8 cycles from FETCH.
- beq with zero=1, then beq with zero=0 → pc_en=1 and pcsrc=01 in the first BEQ cycle; pc_en=0 in the second; aluop=001 in both.
- ori, then andi → IEXEC shows aluop=100, then 011; alusrcb=10; IWB asserts regwrite with regdst=0.
- opcode 111111 → illegal_op pulses for 1 cycle in DECODE; next state is FETCH; instr_count unchanged.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 → bus_error rises and state is HALT, with all other outputs 0; rst_n low clears everything; the cycle after release is RESET, then FETCH.
